// File: rtl/timer_defs.sv
// Shared definitions for the countdown timer: state encoding and default count width.
package timer_defs;

   localparam int TIMER_WIDTH = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot / auto-reload modes and a registered terminal-count pulse.
// Load reaches cnt_out after one edge; a load of N produces tc after N enabled edges.
module countdown_timer
   import timer_defs::*;
#(
   parameter int WIDTH = TIMER_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             enab,
   input  logic             auto_rld,
   input  logic [WIDTH-1:0] cnt_in,
   output logic [WIDTH-1:0] cnt_out,
   output logic             busy,
   output logic             tc,
   output logic             expired
);

   state_t           r_state;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_rld;
   logic             r_tc;
   logic             r_exp;

   state_t           w_state;
   logic [WIDTH-1:0] w_cnt;
   logic [WIDTH-1:0] w_rld;
   logic             w_tc;
   logic             w_exp;

   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_rld   = r_rld;
      w_tc    = 1'b0;
      w_exp   = r_exp;
      if (load) begin
         w_cnt   = cnt_in;
         w_rld   = cnt_in;
         w_exp   = 1'b0;
         w_state = (cnt_in != '0) ? ST_RUN : ST_IDLE;
      end else if (r_state == ST_RUN && enab) begin
         if (r_cnt == WIDTH'(1)) begin
            w_tc = 1'b1;
            if (auto_rld) begin
               w_cnt = r_rld;
            end else begin
               w_cnt   = '0;
               w_state = ST_DONE;
               w_exp   = 1'b1;
            end
         end else if (r_cnt != '0) begin
            // zero never occurs in RUN; the guard keeps the decrement from wrapping
            w_cnt = r_cnt - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_rld   <= '0;
         r_tc    <= 1'b0;
         r_exp   <= 1'b0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_rld   <= w_rld;
         r_tc    <= w_tc;
         r_exp   <= w_exp;
      end
   end

   assign cnt_out = r_cnt;
   assign busy    = (r_state == ST_RUN);
   assign tc      = r_tc;
   assign expired = r_exp;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: a behavioural model checked every cycle plus literal spot checks.
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       rst;
   logic       load;
   logic       enab;
   logic       auto_rld;
   logic [4:0] cnt_in;
   logic [4:0] cnt_out;
   logic       busy;
   logic       tc;
   logic       expired;

   int n_checks = 0;
   int n_err    = 0;

   // Model: count value, reload value, running flag, flags
   int m_cnt, m_rld;
   bit m_run, m_exp, m_tc;

   countdown_timer #(.WIDTH(5)) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .enab     (enab),
      .auto_rld (auto_rld),
      .cnt_in   (cnt_in),
      .cnt_out  (cnt_out),
      .busy     (busy),
      .tc       (tc),
      .expired  (expired)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt = 0; m_rld = 0; m_run = 0; m_exp = 0; m_tc = 0;
      end else begin
         m_tc = 0;
         if (load) begin
            m_cnt = int'(cnt_in);
            m_rld = int'(cnt_in);
            m_exp = 0;
            m_run = (cnt_in != 0);
         end else if (m_run && enab) begin
            if (m_cnt == 1) begin
               m_tc = 1;
               if (auto_rld) m_cnt = m_rld;
               else begin
                  m_cnt = 0; m_run = 0; m_exp = 1;
               end
            end else begin
               m_cnt = m_cnt - 1;
            end
         end
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("model_cnt",     int'(cnt_out), m_cnt);
      chk("model_busy",    int'(busy),    int'(m_run));
      chk("model_tc",      int'(tc),      int'(m_tc));
      chk("model_expired", int'(expired), int'(m_exp));
   end

   // Apply inputs just after a negedge, then wait out one rising edge.
   task automatic drive(input logic l, input logic e, input logic a, input logic [4:0] c);
      load = l; enab = e; auto_rld = a; cnt_in = c;
      @(negedge clk);
   endtask

   task automatic lit(input string name, input int c, input int b, input int t, input int x);
      chk({name, "_cnt"},     int'(cnt_out), c);
      chk({name, "_busy"},    int'(busy),    b);
      chk({name, "_tc"},      int'(tc),      t);
      chk({name, "_expired"}, int'(expired), x);
   endtask

   initial begin
      rst = 1'b1; load = 0; enab = 0; auto_rld = 0; cnt_in = '0;
      #2;
      lit("reset_initial", 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      // one-shot from 3
      drive(1, 0, 0, 5'h03); lit("os_load", 3, 1, 0, 0);
      drive(0, 1, 0, 5'h00); lit("os_2",    2, 1, 0, 0);
      drive(0, 1, 0, 5'h00); lit("os_1",    1, 1, 0, 0);
      drive(0, 1, 0, 5'h00); lit("os_0",    0, 0, 1, 1);
      drive(0, 1, 0, 5'h00); lit("os_hold1", 0, 0, 0, 1);
      drive(0, 1, 0, 5'h00); lit("os_hold2", 0, 0, 0, 1);

      // auto-reload from 2
      drive(1, 0, 1, 5'h02); lit("ar_load", 2, 1, 0, 0);
      drive(0, 1, 1, 5'h00); lit("ar_1a",   1, 1, 0, 0);
      drive(0, 1, 1, 5'h00); lit("ar_2a",   2, 1, 1, 0);
      drive(0, 1, 1, 5'h00); lit("ar_1b",   1, 1, 0, 0);
      drive(0, 1, 1, 5'h00); lit("ar_2b",   2, 1, 1, 0);

      // enable gating
      drive(1, 0, 0, 5'h05); lit("en_load", 5, 1, 0, 0);
      drive(0, 1, 0, 5'h00); lit("en_e1",   4, 1, 0, 0);
      drive(0, 0, 0, 5'h00); lit("en_e0a",  4, 1, 0, 0);
      drive(0, 0, 0, 5'h00); lit("en_e0b",  4, 1, 0, 0);
      drive(0, 1, 0, 5'h00); lit("en_e1b",  3, 1, 0, 0);

      // load overrides a terminal edge
      drive(0, 1, 0, 5'h00); lit("lo_2", 2, 1, 0, 0);
      drive(0, 1, 0, 5'h00); lit("lo_1", 1, 1, 0, 0);
      drive(1, 1, 0, 5'h1F); lit("lo_override", 31, 1, 0, 0);

      // zero load stays idle
      drive(1, 0, 0, 5'h00); lit("zl_load", 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 5'h00); lit("zl_enab", 0, 0, 0, 0);
      end

      // reload value of 1 fires every cycle
      drive(1, 0, 1, 5'h01); lit("r1_load", 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 1, 5'h00); lit("r1_tc", 1, 1, 1, 0);
      end

      // expired set, then asynchronous reset between edges
      drive(1, 0, 0, 5'h01); lit("rs_load", 1, 1, 0, 0);
      drive(0, 1, 0, 5'h00); lit("rs_exp",  0, 0, 1, 1);
      drive(1, 0, 0, 5'h09); lit("rs_load9", 9, 1, 0, 0);
      enab = 1; load = 0;
      #2 rst = 1'b1;
      #1 lit("rs_async", 0, 0, 0, 0);
      @(negedge clk); lit("rs_held", 0, 0, 0, 0);
      rst = 1'b0;
      drive(0, 1, 0, 5'h00); lit("rs_noload", 0, 0, 0, 0);
      drive(1, 0, 0, 5'h02); lit("rs_reload", 2, 1, 0, 0);
      drive(0, 1, 0, 5'h00); lit("rs_count", 1, 1, 0, 0);
      drive(0, 0, 0, 5'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
